fib_table_reader: RTL and testbench



---
 rtl/fib_pkg.sv | 16 +
 rtl/fib_checker.sv | 63 ++++++
 rtl/fib_table_reader.sv | 109 ++++++++++
 tb/tb_fib_table_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared FSM encoding and table geometry for the Fibonacci table blocks
package fib_pkg;

  localparam int FIB_ADDR_W    = 5;
  localparam int FIB_DATA_W    = 32;
  localparam int FIB_N_ENTRIES = 31;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_LATCH = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } fib_state_e;

endpackage

// File: rtl/fib_checker.sv
// rtl/fib_checker.sv - recurrence history, modular sum compare and sticky first-error capture
module fib_checker import fib_pkg::*; #(
  parameter int ADDR_W = FIB_ADDR_W,
  parameter int DATA_W = FIB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] data,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  logic [DATA_W-1:0] prev1_q, prev1_d;
  logic [DATA_W-1:0] prev2_q, prev2_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [DATA_W-1:0] sum;

  // Same-width add: the carry out is intentionally dropped.
  assign sum = prev1_q + prev2_q;

  always_comb begin
    prev1_d    = prev1_q;
    prev2_d    = prev2_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (clear) begin
      prev1_d    = '0;
      prev2_d    = '0;
      err_d      = 1'b0;
      err_addr_d = '0;
    end else if (load) begin
      prev2_d = prev1_q;
      prev1_d = data;
      // Entries 0 and 1 are seeds; only the first mismatch is recorded.
      if ((idx >= ADDR_W'(2)) && (data != sum) && !err_q) begin
        err_d      = 1'b1;
        err_addr_d = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev1_q    <= '0;
      prev2_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      prev1_q    <= prev1_d;
      prev2_q    <= prev2_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule

// File: rtl/fib_table_reader.sv
// rtl/fib_table_reader.sv - drains the Fibonacci table over RAM port B and streams it out with its index
module fib_table_reader import fib_pkg::*; #(
  parameter int ADDR_W    = FIB_ADDR_W,
  parameter int DATA_W    = FIB_DATA_W,
  parameter int N_ENTRIES = FIB_N_ENTRIES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_doutb,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ENTRIES - 1);

  fib_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              chk_clear;
  logic              chk_load;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    index_d   = index_q;
    chk_clear = 1'b0;
    chk_load  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ADDR;
          idx_d     = '0;
          addr_d    = '0;
          chk_clear = 1'b1;
        end
      end
      ST_ADDR: state_d = ST_LATCH;
      ST_LATCH: begin
        data_d   = ram_doutb;
        index_d  = idx_q;
        chk_load = 1'b1;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            addr_d  = idx_q + 1'b1;
            state_d = ST_ADDR;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      index_q <= index_d;
    end
  end

  fib_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_checker (
    .clk      (clk),
    .rst      (rst),
    .clear    (chk_clear),
    .load     (chk_load),
    .idx      (idx_q),
    .data     (ram_doutb),
    .err      (err),
    .err_addr (err_addr)
  );

  assign ram_addrb = addr_q;
  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q == ST_ADDR) || (state_q == ST_LATCH) || (state_q == ST_OUT);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_fib_table_reader.sv
// tb/tb_fib_table_reader.sv - randomized self-checking bench against a table-level reference model
module tb_fib_table_reader;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 31;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_doutb;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] err_addr;

  fib_table_reader #(.ADDR_W(AW), .DATA_W(DW), .N_ENTRIES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb),
    .out_data  (out_data),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  // Port-B RAM model: one cycle read latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) ram_doutb <= ram[ram_addrb];

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int exp_fe = -1;
  int done_cnt = 0;
  int idx4_cycles = 0;
  int stall_cnt = 0;
  int ready_mode = 0;
  bit pass_active = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_err();
    logic [DW-1:0] s;
    for (int i = 2; i < N; i++) begin
      s = ram[i-1] + ram[i-2];
      if (ram[i] !== s) return i;
    end
    return -1;
  endfunction

  task automatic fill_fib(logic [DW-1:0] a, logic [DW-1:0] b);
    ram[0] = a;
    ram[1] = b;
    for (int i = 2; i < (1 << AW); i++) ram[i] = ram[i-1] + ram[i-2];
  endtask

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (out_valid && out_index == AW'(4) && stall_cnt < 5) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Compare process: every visible beat must be the next expected table entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (!pass_active || exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          check("beat_index", out_index, exp_q[0]);
          check("beat_data", out_data, ram[exp_q[0]]);
          check("addr_held", ram_addrb, out_index);
          check("busy_in_out", busy, 1'b1);
          check("err_live", err, (exp_fe >= 0) && (exp_fe <= int'(out_index)));
          check("err_addr_live", err_addr,
                ((exp_fe >= 0) && (exp_fe <= int'(out_index))) ? exp_fe : 0);
          if (out_index == AW'(4)) idx4_cycles++;
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        check("done_expected", pass_active, 1'b1);
        check("done_all_beats", exp_q.size(), 0);
        check("done_not_busy", busy, 1'b0);
      end
    end
  end

  task automatic begin_pass();
    exp_fe = first_err();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(i);
    done_cnt    = 0;
    idx4_cycles = 0;
    stall_cnt   = 0;
    pass_active = 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("addr_state_busy", busy, 1'b1);
    check("addr_state_no_valid", out_valid, 1'b0);
    check("addr_state_addr0", ram_addrb, 0);
  endtask

  task automatic run_pass(int mode, bit poke);
    int cyc;
    bit got;
    bit poked;
    ready_mode = mode;
    begin_pass();
    if (poke) start = 1'b1;
    cyc = 0;
    got = 0;
    poked = 0;
    while (!got && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (cyc == 1) check("first_beat_not_early", out_valid, 1'b0);
      if (cyc == 2) check("first_beat_latency", out_valid, 1'b1);
      if (poke && !poked && out_valid) begin
        start = 1'b1;
        poked = 1;
      end
      if (done) got = 1;
    end
    check("done_seen", got, 1'b1);
    if (mode == 0) check("pass_cycles", cyc, 3 * N);
    check("final_err", err, exp_fe >= 0);
    check("final_err_addr", err_addr, (exp_fe >= 0) ? exp_fe : 0);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 1'b0);
    check("idle_not_busy", busy, 1'b0);
    check("done_count", done_cnt, 1);
    check("err_held_after_done", err, exp_fe >= 0);
    if (mode == 2) check("stall_hold_cycles", idx4_cycles, 6);
    pass_active = 0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_addrb"}, ram_addrb, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_index"}, out_index, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_err_addr"}, err_addr, 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start = 1'b0;
    fill_fib(32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Pin the model against hand-computed values.
    check("model_f30", ram[30], 32'd832040);
    check("model_clean", first_err(), -1);
    run_pass(0, 0);

    ram[10] = 32'd56;
    check("model_corrupt_at", first_err(), 10);
    run_pass(0, 0);
    check("corrupt_err_addr_lit", err_addr, 10);

    fill_fib(32'hFFFF_FFFF, 32'd1);
    check("model_wrap_e2", ram[2], 32'd0);
    check("model_wrap_clean", first_err(), -1);
    run_pass(0, 0);
    check("wrap_err_lit", err, 1'b0);

    fill_fib(32'd0, 32'd1);
    run_pass(2, 0);

    // Reset during the OUT cycle of beat 7.
    ready_mode = 0;
    begin_pass();
    cyc = 0;
    while (!(out_valid && out_index == AW'(7)) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("reached_beat7", out_valid && out_index == AW'(7), 1'b1);
    rst = 1'b1;
    pass_active = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt, 0);
    run_pass(0, 0);

    run_pass(0, 1);

    for (int r = 0; r < 8; r++) begin
      fill_fib($urandom, $urandom);
      if ($urandom_range(0, 1) == 1) ram[$urandom_range(2, N - 1)] = $urandom;
      run_pass(1, r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
